// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ROB tag width and the reservation-station entry.
// RS_AGE_ISSUE_EN adds a per-entry age field used for oldest-first issue.
package cpu_pkg;

  localparam int TAG_W    = 3;
  localparam int RS_AGE_W = 3;  // wide enough for the largest supported DEPTH of 8

  localparam logic [4:0] ADD    = 5'd0;
  localparam logic [4:0] SUB    = 5'd1;
  localparam logic [4:0] AND_OP = 5'd2;
  localparam logic [4:0] OR_OP  = 5'd3;
  localparam logic [4:0] XOR_OP = 5'd4;
  localparam logic [4:0] SLL    = 5'd5;
  localparam logic [4:0] SRL    = 5'd6;
  localparam logic [4:0] SRA    = 5'd7;
  localparam logic [4:0] SLT    = 5'd8;
  localparam logic [4:0] SLTU   = 5'd9;
  localparam logic [4:0] LUI    = 5'd10;
  localparam logic [4:0] AUIPC  = 5'd11;
  localparam logic [4:0] BEQ    = 5'd12;
  localparam logic [4:0] BNE    = 5'd13;
  localparam logic [4:0] BGE    = 5'd14;
  localparam logic [4:0] BGEU   = 5'd15;
  localparam logic [4:0] JAL    = 5'd16;
  localparam logic [4:0] JALR   = 5'd17;
  localparam logic [4:0] LB     = 5'd18;
  localparam logic [4:0] LH     = 5'd19;
  localparam logic [4:0] LW     = 5'd20;
  localparam logic [4:0] LBU    = 5'd21;
  localparam logic [4:0] LHU    = 5'd22;
  localparam logic [4:0] SB     = 5'd23;
  localparam logic [4:0] SH     = 5'd24;
  localparam logic [4:0] SW     = 5'd25;
  localparam logic [4:0] BLT    = 5'd26;
  localparam logic [4:0] BLTU   = 5'd27;
  localparam logic [4:0] FENCE  = 5'd28;
  localparam logic [4:0] ECALL  = 5'd29;
  localparam logic [4:0] JAL_C  = 5'd30;
  localparam logic [4:0] NOP_OP = 5'b11111;

  // Loads/stores belong to the load-store buffer; only ALU-class ops land here.
  function automatic logic rs_accepts(input logic [4:0] op);
    return (op <= JALR) || (op == BLT) || (op == BLTU);
  endfunction

  typedef struct packed {
    logic             valid;
    logic [4:0]       op;
    logic [31:0]      v1;
    logic [31:0]      v2;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic [31:0]      imm;
    logic [TAG_W-1:0] dest;
    logic             is_branch;
`ifdef RS_AGE_ISSUE_EN
    logic [RS_AGE_W-1:0] age;
`endif
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Issue picker: lowest-index ready entry, or oldest ready entry when
// RS_AGE_ISSUE_EN is defined.
module rs_select
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [DEPTH-1:0]                ready,
`ifdef RS_AGE_ISSUE_EN
  input  logic [DEPTH-1:0][RS_AGE_W-1:0]  ages,
`endif
  output logic [IDX_W-1:0]                grant,
  output logic                            any_ready
);

`ifdef RS_AGE_ISSUE_EN
  logic [RS_AGE_W-1:0] best_age;
  logic                found;

  // Ages of valid entries are distinct, so the strict compare never ties.
  always_comb begin
    grant     = '0;
    any_ready = |ready;
    best_age  = '0;
    found     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || ages[i] > best_age)) begin
        found    = 1'b1;
        best_age = ages[i];
        grant    = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    grant     = '0;
    any_ready = |ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) grant = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station between ROB dispatch and the ALU.
// Define RS_AGE_ISSUE_EN for oldest-first issue instead of lowest-index.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op_in,
  input  logic [31:0]      value1_in,
  input  logic [31:0]      value2_in,
  input  logic [TAG_W-1:0] query1_in,
  input  logic [TAG_W-1:0] query2_in,
  input  logic [31:0]      imm_in,
  input  logic [TAG_W-1:0] target_in,
  input  logic             is_branch_in,
  input  logic [TAG_W-1:0] alu_num,
  input  logic [31:0]      alu_value,
  input  logic             alu_is_branch,
  input  logic [TAG_W-1:0] mem_num,
  input  logic [31:0]      mem_value,
  output logic             rs_full,
  output logic             issue_valid,
  output logic [4:0]       issue_op,
  output logic [31:0]      issue_a,
  output logic [31:0]      issue_b,
  output logic [31:0]      issue_imm,
  output logic [TAG_W-1:0] issue_dest,
  output logic             issue_is_branch
);
  import cpu_pkg::*;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rs_entry_t        entries_reg  [DEPTH];
  rs_entry_t        entries_next [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] grant;
  logic             any_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic             has_free;
  logic             do_alloc;
  logic [CNT_W-1:0] occ_next;
  logic             full_next;

  // Load results take priority; branch compares never produce register values.
  function automatic logic [TAG_W+31:0] snoop(
    input logic [TAG_W-1:0] q,     input logic [31:0] v,
    input logic [TAG_W-1:0] m_num, input logic [31:0] m_val,
    input logic [TAG_W-1:0] a_num, input logic [31:0] a_val,
    input logic             a_br
  );
    if (q != '0 && q == m_num)          return {{TAG_W{1'b0}}, m_val};
    if (q != '0 && q == a_num && !a_br) return {{TAG_W{1'b0}}, a_val};
    return {q, v};
  endfunction

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
      assign ready[gi] = entries_reg[gi].valid && (entries_reg[gi].q1 == '0) &&
                         (entries_reg[gi].q2 == '0);
    end
  endgenerate

`ifdef RS_AGE_ISSUE_EN
  logic [DEPTH-1:0][RS_AGE_W-1:0] ages;
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign ages[gi] = entries_reg[gi].age;
    end
  endgenerate

  rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .ready(ready), .ages(ages), .grant(grant), .any_ready(any_ready)
  );
`else
  rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .ready(ready), .grant(grant), .any_ready(any_ready)
  );
`endif

  always_comb begin
    has_free  = 1'b0;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entries_reg[i].valid) begin
        has_free  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
    // A slot freed by this edge's issue is not visible here, by design.
    do_alloc = rs_accepts(op_in) && has_free;

    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_next[i] = entries_reg[i];
      {entries_next[i].q1, entries_next[i].v1} = snoop(entries_reg[i].q1, entries_reg[i].v1,
          mem_num, mem_value, alu_num, alu_value, alu_is_branch);
      {entries_next[i].q2, entries_next[i].v2} = snoop(entries_reg[i].q2, entries_reg[i].v2,
          mem_num, mem_value, alu_num, alu_value, alu_is_branch);
      if (any_ready && grant == IDX_W'(i)) begin
        entries_next[i].valid = 1'b0;
      end
`ifdef RS_AGE_ISSUE_EN
      // Age counts younger live entries: bump on allocation, drop when a younger one issues.
      else if (entries_reg[i].valid) begin
        entries_next[i].age = entries_reg[i].age + RS_AGE_W'(do_alloc) -
            RS_AGE_W'(any_ready && (entries_reg[i].age > entries_reg[grant].age));
      end
`endif
      if (do_alloc && alloc_idx == IDX_W'(i)) begin
        entries_next[i].valid     = 1'b1;
        entries_next[i].op        = op_in;
        {entries_next[i].q1, entries_next[i].v1} = snoop(query1_in, value1_in,
            mem_num, mem_value, alu_num, alu_value, alu_is_branch);
        {entries_next[i].q2, entries_next[i].v2} = snoop(query2_in, value2_in,
            mem_num, mem_value, alu_num, alu_value, alu_is_branch);
        entries_next[i].imm       = imm_in;
        entries_next[i].dest      = target_in;
        entries_next[i].is_branch = is_branch_in;
`ifdef RS_AGE_ISSUE_EN
        entries_next[i].age       = '0;
`endif
      end
      occ_next = occ_next + CNT_W'(entries_next[i].valid);
    end
    full_next = (occ_next >= CNT_W'(DEPTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
      rs_full         <= 1'b0;
      issue_valid     <= 1'b0;
      issue_op        <= NOP_OP;
      issue_a         <= '0;
      issue_b         <= '0;
      issue_imm       <= '0;
      issue_dest      <= '0;
      issue_is_branch <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= entries_next[i];
      rs_full <= full_next;
      if (any_ready) begin
        issue_valid     <= 1'b1;
        issue_op        <= entries_reg[grant].op;
        issue_a         <= entries_reg[grant].v1;
        issue_b         <= entries_reg[grant].v2;
        issue_imm       <= entries_reg[grant].imm;
        issue_dest      <= entries_reg[grant].dest;
        issue_is_branch <= entries_reg[grant].is_branch;
      end else begin
        issue_valid     <= 1'b0;
        issue_op        <= NOP_OP;
        issue_a         <= '0;
        issue_b         <= '0;
        issue_imm       <= '0;
        issue_dest      <= '0;
        issue_is_branch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station; honours RS_AGE_ISSUE_EN for the age-ordering case.
module tb_reservation_station;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       op_in;
  logic [31:0]      value1_in, value2_in, imm_in;
  logic [TAG_W-1:0] query1_in, query2_in, target_in;
  logic             is_branch_in;
  logic [TAG_W-1:0] alu_num, mem_num;
  logic [31:0]      alu_value, mem_value;
  logic             alu_is_branch;
  logic             rs_full, issue_valid, issue_is_branch;
  logic [4:0]       issue_op;
  logic [31:0]      issue_a, issue_b, issue_imm;
  logic [TAG_W-1:0] issue_dest;

  int n_checks = 0;
  int n_errors = 0;
  int occ = 0;
  int first_dest, second_dest;

  reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .op_in(op_in), .value1_in(value1_in), .value2_in(value2_in),
    .query1_in(query1_in), .query2_in(query2_in), .imm_in(imm_in),
    .target_in(target_in), .is_branch_in(is_branch_in),
    .alu_num(alu_num), .alu_value(alu_value), .alu_is_branch(alu_is_branch),
    .mem_num(mem_num), .mem_value(mem_value),
    .rs_full(rs_full), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_imm(issue_imm),
    .issue_dest(issue_dest), .issue_is_branch(issue_is_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dispatch into a station with no free slot is an upstream protocol violation.
  always @(posedge clk) begin
    if (rst && rs_accepts(op_in)) begin
      assert (occ < DEPTH) else $error("dispatch into a full station, op=%0d", op_in);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    op_in = NOP_OP; value1_in = '0; value2_in = '0; imm_in = '0;
    query1_in = '0; query2_in = '0; target_in = '0; is_branch_in = 1'b0;
    alu_num = '0; alu_value = '0; alu_is_branch = 1'b0;
    mem_num = '0; mem_value = '0;
  endtask

  task automatic dispatch(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [TAG_W-1:0] q1, input logic [TAG_W-1:0] q2,
                          input logic [31:0] imm, input logic [TAG_W-1:0] tgt, input logic br);
    op_in = op; value1_in = v1; value2_in = v2; query1_in = q1; query2_in = q2;
    imm_in = imm; target_in = tgt; is_branch_in = br;
    $display("dispatch op=%0d q1=%0d q2=%0d v1=%0h v2=%0h dest=%0d", op, q1, q2, v1, v2, tgt);
  endtask

  task automatic step();
    int acc;
    acc = (rst && rs_accepts(op_in)) ? 1 : 0;
    @(posedge clk);
    #1;
    occ = occ + acc - (issue_valid ? 1 : 0);
    idle_inputs();
  endtask

  task automatic expect_issue(input string tag, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [TAG_W-1:0] dest);
    check({tag, "_valid"}, issue_valid, 1);
    check({tag, "_op"}, issue_op, op);
    check({tag, "_a"}, issue_a, a);
    check({tag, "_b"}, issue_b, b);
    check({tag, "_dest"}, issue_dest, dest);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #23;
    check("reset_valid", issue_valid, 0);
    check("reset_op", issue_op, 5'b11111);
    check("reset_dest", issue_dest, 0);
    check("reset_full", rs_full, 0);
    check("reset_a", issue_a, 0);
    rst = 1'b1;

    // Mid-run reset: three pending entries plus one issuing.
    dispatch(ADD, 0, 0, 1, 0, 0, 1, 0); step();
    dispatch(ADD, 0, 0, 1, 0, 0, 2, 0); step();
    dispatch(ADD, 0, 0, 1, 0, 0, 3, 0); step();
    check("fill3_full", rs_full, 1);
    dispatch(ADD, 32'h11, 32'h22, 0, 0, 0, 4, 0); step();
    check("fill4_noissue", issue_valid, 0);
    step();
    expect_issue("pre_reset", ADD, 32'h11, 32'h22, 4);
    #3 rst = 1'b0;
    occ = 0;
    #1;
    check("midrst_valid", issue_valid, 0);
    check("midrst_full", rs_full, 0);
    check("midrst_op", issue_op, 5'b11111);
    #2 rst = 1'b1;
    alu_num = 1; alu_value = 32'hAA;
    dispatch(ADD, 5, 7, 0, 0, 0, 2, 0); step();
    check("post_rst_lat", issue_valid, 0);
    step();
    expect_issue("post_rst", ADD, 5, 7, 2);
    step();
    check("post_rst_drained", issue_valid, 0);
    check("post_rst_full", rs_full, 0);

    // Wakeup through the ALU broadcast.
    dispatch(SUB, 32'hDEAD, 1, 3, 0, 0, 4, 0); step();
    step();
    check("wake_wait", issue_valid, 0);
    alu_num = 3; alu_value = 10; step();
    check("wake_edge", issue_valid, 0);
    step();
    expect_issue("wake", SUB, 10, 1, 4);

    // Same-cycle capture from the load broadcast.
    mem_num = 5; mem_value = 9;
    dispatch(BEQ, 3, 32'hBEEF, 0, 5, 32'h40, 5, 1); step();
    check("capture_lat", issue_valid, 0);
    step();
    expect_issue("capture", BEQ, 3, 9, 5);
    check("capture_br", issue_is_branch, 1);
    check("capture_imm", issue_imm, 32'h40);

    // Load broadcast beats ALU broadcast on the same tag at dispatch.
    alu_num = 2; alu_value = 32'h111; mem_num = 2; mem_value = 32'h222;
    dispatch(ADD, 0, 4, 2, 0, 0, 7, 0); step();
    step();
    expect_issue("prio", ADD, 32'h222, 4, 7);

    // Branch-compare broadcasts never wake operands.
    dispatch(BNE, 0, 6, 5, 0, 0, 6, 1); step();
    alu_num = 5; alu_value = 77; alu_is_branch = 1; step();
    step();
    check("brfilt_hold1", issue_valid, 0);
    alu_num = 5; alu_value = 78; alu_is_branch = 1;
    dispatch(OR_OP, 0, 1, 5, 0, 0, 3, 0); step();
    step();
    check("brfilt_hold2", issue_valid, 0);
    mem_num = 5; mem_value = 32'h55; step();
    step();
    expect_issue("brfilt_rel", BNE, 32'h55, 6, 6);
    step();
    expect_issue("brfilt_rel2", OR_OP, 32'h55, 1, 3);
    step();

    // Fill to the full threshold, then release one.
    dispatch(XOR_OP, 0, 1, 7, 0, 0, 1, 0); step();
    dispatch(XOR_OP, 0, 2, 6, 0, 0, 2, 0); step();
    check("full_at2", rs_full, 0);
    dispatch(XOR_OP, 0, 3, 6, 0, 0, 3, 0); step();
    check("full_at3", rs_full, 1);
    alu_num = 7; alu_value = 32'h70; step();
    check("full_wake", rs_full, 1);
    step();
    expect_issue("full_rel", XOR_OP, 32'h70, 1, 1);
    check("full_clear", rs_full, 0);
    mem_num = 6; mem_value = 32'h60; step();
    step();
    expect_issue("drain_a", XOR_OP, 32'h60, 2, 2);
    step();
    expect_issue("drain_b", XOR_OP, 32'h60, 3, 3);
    step();

    // Loads/stores and other foreign ops are ignored.
    dispatch(ADD, 0, 0, 4, 0, 0, 1, 0); step();
    dispatch(ADD, 0, 0, 4, 0, 0, 2, 0); step();
    dispatch(LW, 1, 2, 0, 0, 0, 5, 0); step();
    check("lw_full", rs_full, 0);
    dispatch(SB, 1, 2, 0, 0, 0, 5, 0); step();
    check("sb_full", rs_full, 0);
    check("lw_noissue", issue_valid, 0);
    dispatch(5'd28, 1, 2, 0, 0, 0, 5, 0); step();
    check("op28_full", rs_full, 0);
    check("sb_noissue", issue_valid, 0);
    step();
    check("op28_noissue", issue_valid, 0);
    mem_num = 4; mem_value = 32'h44; step();
    step();
    expect_issue("filt_drain_a", ADD, 32'h44, 0, 1);
    step();
    expect_issue("filt_drain_b", ADD, 32'h44, 0, 2);
    step();
    check("filt_empty", issue_valid, 0);

    // Boundary opcodes that are accepted.
    dispatch(BLT, 8, 9, 0, 0, 32'h10, 3, 1); step();
    dispatch(JALR, 32'h100, 0, 0, 0, 32'h4, 4, 0); step();
    expect_issue("blt", BLT, 8, 9, 3);
    step();
    expect_issue("jalr", JALR, 32'h100, 0, 4);
    step();

    // Age ordering: entry 2 older than entry 0, both woken together.
    dispatch(AND_OP, 0, 1, 1, 0, 0, 1, 0); step();
    dispatch(AND_OP, 0, 2, 2, 0, 0, 2, 0); step();
    dispatch(AND_OP, 0, 3, 3, 0, 0, 3, 0); step();
    alu_num = 1; alu_value = 32'h11;
    dispatch(AND_OP, 0, 5, 2, 0, 0, 5, 0); step();
    check("age_full4", rs_full, 1);
    step();
    expect_issue("age_x", AND_OP, 32'h11, 1, 1);
    dispatch(AND_OP, 0, 4, 3, 0, 0, 4, 0); step();
    alu_num = 3; alu_value = 32'h33; step();
    check("age_wake", issue_valid, 0);
`ifdef RS_AGE_ISSUE_EN
    first_dest = 3; second_dest = 4;
`else
    first_dest = 4; second_dest = 3;
`endif
    step();
    check("age_first", issue_dest, first_dest);
    check("age_first_v", issue_valid, 1);
    step();
    check("age_second", issue_dest, second_dest);
    mem_num = 2; mem_value = 32'h22; step();
    step();
    expect_issue("age_y", AND_OP, 32'h22, 2, 2);
    step();
    expect_issue("age_z", AND_OP, 32'h22, 5, 5);
    step();
    check("age_done", issue_valid, 0);
    check("age_done_full", rs_full, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
